keypad_scanner: RTL

- Parametrised matrix-keypad scanner and debouncer, successor to the fixed 3x3 scan-and-LED logic.
- Drives NUM_ROWS active-low row lines in round-robin and samples NUM_COLS active-low column inputs through a synchroniser.
- Debounces across full scans and emits a registered key code with one-cycle press and release strobes.
- Sits between the keypad pins and the lock/code-entry logic.

---
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: round-robin active-low row drive, two-flop column
// synchroniser, per-scan single-key detection and multi-scan debounce with
// registered key code and one-cycle press/release strobes.
module keypad_scanner #(
  parameter int NUM_ROWS       = 3,
  parameter int NUM_COLS       = 3,
  parameter int ROW_PERIOD     = 130000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CODE_W         = 4
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic                scan_en,
  output logic [NUM_ROWS-1:0] row_n,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_release,
  output logic                key_held
);

  localparam int CNT_W = $clog2(ROW_PERIOD);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(ROW_PERIOD - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [STB_W-1:0]    STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [NUM_ROWS-1:0] ROW_RST  = ~(NUM_ROWS'(1));

  // Number of pressed keys seen so far in a scan; only none/one/many matters.
  typedef enum logic [1:0] {
    HITS_NONE,
    HITS_ONE,
    HITS_MANY
  } hits_e;

  function automatic hits_e hits_add(input hits_e a, input hits_e b);
    if (a == HITS_NONE) return b;
    if (b == HITS_NONE) return a;
    return HITS_MANY;
  endfunction

  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
    logic [NUM_ROWS-1:0] drv;
    drv = '1;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (idx == ROW_W'(r)) drv[r] = 1'b0;
    end
    return drv;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [NUM_ROWS-1:0] row_n_q, row_n_d;
  logic [NUM_COLS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                en_q, en_d;
  hits_e               acc_hits_q, acc_hits_d;
  logic [CODE_W-1:0]   acc_code_q, acc_code_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_release_q, key_release_d;

  hits_e               row_hits, tot_hits;
  logic [CODE_W-1:0]   row_code, sel_code, scan_result;
  logic [ROW_W-1:0]    row_next;

  // Pressed keys on the currently driven row, from the synchronised columns.
  always_comb begin
    row_hits = HITS_NONE;
    row_code = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (!sync2_q[c]) begin
        row_hits = (row_hits == HITS_NONE) ? HITS_ONE : HITS_MANY;
        row_code = CODE_W'(32'(row_idx_q) * 32'(NUM_COLS) + c + 32'd1);
      end
    end
  end

  // Row sequencing, scan accumulation, debounce and commit.
  always_comb begin
    cnt_d         = cnt_q;
    row_idx_d     = row_idx_q;
    row_n_d       = row_n_q;
    sync1_d       = col_n;
    sync2_d       = sync1_q;
    en_d          = scan_en;
    acc_hits_d    = acc_hits_q;
    acc_code_d    = acc_code_q;
    cand_d        = cand_q;
    stable_d      = stable_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    row_next      = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);
    tot_hits      = hits_add(acc_hits_q, row_hits);
    sel_code      = (row_hits != HITS_NONE) ? row_code : acc_code_q;
    scan_result   = '0;

    if (!scan_en) begin
      row_n_d = '1;
    end else if (!en_q) begin
      // First enabled cycle after a freeze: re-drive the held row and start its
      // dwell from zero once the drive is actually on the pins; the partial
      // scan is dropped.
      cnt_d      = '0;
      acc_hits_d = HITS_NONE;
      acc_code_d = '0;
      row_n_d    = row_drive(row_idx_q);
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      row_idx_d = row_next;
      row_n_d   = row_drive(row_next);
      if (row_idx_q == ROW_LAST) begin
        scan_result = (tot_hits == HITS_ONE) ? sel_code : '0;
        acc_hits_d  = HITS_NONE;
        acc_code_d  = '0;
        if (scan_result == cand_q) begin
          if (stable_q != STB_MAX) stable_d = stable_q + STB_W'(1);
        end else begin
          cand_d   = scan_result;
          stable_d = STB_W'(1);
        end
        if (stable_d == STB_MAX && cand_d != key_code_q) begin
          key_code_d    = cand_d;
          key_valid_d   = |cand_d;
          key_release_d = |key_code_q;
        end
      end else begin
        acc_hits_d = tot_hits;
        acc_code_d = sel_code;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      row_idx_q     <= '0;
      row_n_q       <= ROW_RST;
      sync1_q       <= '1;
      sync2_q       <= '1;
      en_q          <= 1'b1;
      acc_hits_q    <= HITS_NONE;
      acc_code_q    <= '0;
      cand_q        <= '0;
      stable_q      <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      row_idx_q     <= row_idx_d;
      row_n_q       <= row_n_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      en_q          <= en_d;
      acc_hits_q    <= acc_hits_d;
      acc_code_q    <= acc_code_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
    end
  end

  assign row_n       = row_n_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign key_held    = |key_code_q;

endmodule
